// File: rtl/jtframe_psx_poll.sv
// Round-robin PlayStation pad poller: digital (ID 0x41) and analog (ID 0x73) replies.
// Define JTFRAME_PSX_VIB_EN to drive TX bytes 3/4 from vib_small/vib_large.
module jtframe_psx_poll #(
  parameter int unsigned CLKDIV   = 50,
  parameter int unsigned PADS     = 2,
  parameter int unsigned ACK_TO   = 1000,
  parameter int unsigned GAP      = 100,
  parameter int unsigned POLL_CYC = 800000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psx_dat,
  input  logic                 psx_ack,
  output logic                 psx_clk,
  output logic [PADS-1:0]      psx_sel,
  output logic                 psx_cmd,
  output logic [16*PADS-1:0]   buttons,
  output logic [32*PADS-1:0]   analog,
  output logic [PADS-1:0]      analog_mode,
  output logic [PADS-1:0]      pad_ok,
  output logic                 upd,
  output logic [1:0]           upd_pad,
  input  logic                 vib_small,
  input  logic [7:0]           vib_large
);

  localparam int unsigned T1   = (CLKDIV > GAP) ? CLKDIV : GAP;
  localparam int unsigned T2   = (ACK_TO > POLL_CYC) ? ACK_TO : POLL_CYC;
  localparam int unsigned TMAX = (T1 > T2) ? T1 : T2;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned PW   = (PADS > 1) ? $clog2(PADS) : 1;

  localparam logic [TW-1:0] DIV_END  = TW'(CLKDIV - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP - 1);
  localparam logic [TW-1:0] ACK_END  = TW'(ACK_TO - 1);
  localparam logic [TW-1:0] POLL_END = TW'(POLL_CYC - 1);
  localparam logic [PW-1:0] LAST_PAD = PW'(PADS - 1);
  localparam logic [32*PADS-1:0] ANA_IDLE = {(4*PADS){8'h80}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_SHIFT, ST_ACKW, ST_GAP, ST_DESEL, ST_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pad_q, pad_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [3:0]          byte_q, byte_d;
  logic [7:0]          sh_q, sh_d;
  logic [7:0]          id_q, id_d;
  logic [47:0]         rxb_q, rxb_d;
  logic                acks_q, acks_d;
  logic                clk_q, clk_d;
  logic                cmd_q, cmd_d;
  logic [PADS-1:0]     sel_q, sel_d;
  logic [16*PADS-1:0]  btn_q, btn_d;
  logic [32*PADS-1:0]  ana_q, ana_d;
  logic [PADS-1:0]     amode_q, amode_d;
  logic [PADS-1:0]     ok_q, ok_d;
  logic                upd_q, upd_d;
  logic [1:0]          updp_q, updp_d;

  logic [7:0]          tx_cur;
  logic                is_analog, id_valid, last_byte;
  logic                commit, commit_good;
  logic [15:0]         btn_new;
  logic [31:0]         ana_new;

  always_comb begin
    tx_cur = 8'h00;
    case (byte_q)
      4'd0: tx_cur = 8'h01;
      4'd1: tx_cur = 8'h42;
`ifdef JTFRAME_PSX_VIB_EN
      4'd3: tx_cur = vib_small ? 8'hFF : 8'h00;
      4'd4: tx_cur = vib_large;
`endif
      default: tx_cur = 8'h00;
    endcase
  end

`ifndef JTFRAME_PSX_VIB_EN
  logic vib_unused;
  assign vib_unused = ^{vib_small, vib_large};
`endif

  assign is_analog = (id_q == 8'h73);
  assign id_valid  = (id_q == 8'h41) || is_analog;
  assign last_byte = (byte_q == (is_analog ? 4'd8 : 4'd4));

  always_comb begin
    state_d     = state_q;
    pad_d       = pad_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sh_d        = sh_q;
    id_d        = id_q;
    rxb_d       = rxb_q;
    acks_d      = acks_q;
    clk_d       = clk_q;
    cmd_d       = cmd_q;
    sel_d       = sel_q;
    btn_d       = btn_q;
    ana_d       = ana_q;
    amode_d     = amode_q;
    ok_d        = ok_q;
    upd_d       = 1'b0;
    updp_d      = updp_q;
    commit      = 1'b0;
    commit_good = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pad_d   = '0;
        cnt_d   = '0;
        byte_d  = '0;
        sel_d   = ~(PADS'(1));
        state_d = ST_SEL;
      end

      ST_SEL, ST_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          acks_d  = 1'b0;
          clk_d   = 1'b0;
          cmd_d   = tx_cur[0];
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      ST_SHIFT: begin
        // ACK during the final high phase is remembered so ACKW cannot miss an early pulse
        if (clk_q && (bit_q == 3'd7) && !psx_ack) acks_d = 1'b1;
        if (cnt_q != DIV_END) begin
          cnt_d = cnt_q + TW'(1);
        end else begin
          cnt_d = '0;
          if (!clk_q) begin
            clk_d = 1'b1;
            sh_d  = {psx_dat, sh_q[7:1]};
          end else if (bit_q != 3'd7) begin
            clk_d = 1'b0;
            bit_d = bit_q + 3'd1;
            cmd_d = tx_cur[bit_d];
          end else begin
            cmd_d = 1'b1;
            if (byte_q == 4'd1) id_d = sh_q;
            if (byte_q >= 4'd3) rxb_d = {sh_q, rxb_q[47:8]};
            if ((byte_q == 4'd2) && ((sh_q != 8'h5A) || !id_valid)) begin
              commit = 1'b1;
            end else if ((byte_q >= 4'd4) && last_byte) begin
              commit      = 1'b1;
              commit_good = 1'b1;
            end else begin
              byte_d  = byte_q + 4'd1;
              state_d = ST_ACKW;
            end
          end
        end
      end

      ST_ACKW: begin
        if (acks_q || !psx_ack) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == ACK_END) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      ST_DESEL: begin
        if (cnt_q == GAP_END) begin
          cnt_d  = '0;
          byte_d = '0;
          if (pad_q == LAST_PAD) begin
            pad_d   = '0;
            state_d = ST_WAIT;
          end else begin
            pad_d   = pad_q + PW'(1);
            sel_d   = ~(PADS'(1) << pad_d);
            state_d = ST_SEL;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      ST_WAIT: begin
        if (cnt_q == POLL_END) begin
          cnt_d   = '0;
          byte_d  = '0;
          sel_d   = ~(PADS'(1) << pad_q);
          state_d = ST_SEL;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Digital replies leave {rx4,rx3} in the top of the shift window; analog fills all six bytes
    btn_new = is_analog ? ~rxb_d[15:0] : ~rxb_d[47:32];
    ana_new = is_analog ? rxb_d[47:16] : 32'h80808080;

    if (commit) begin
      state_d = ST_DESEL;
      cnt_d   = '0;
      sel_d   = '1;
      clk_d   = 1'b1;
      cmd_d   = 1'b1;
      upd_d   = 1'b1;
      updp_d  = 2'(pad_q);
      for (int unsigned i = 0; i < PADS; i++) begin
        if (pad_q == PW'(i)) begin
          btn_d[16*i +: 16] = commit_good ? btn_new : 16'h0000;
          ana_d[32*i +: 32] = commit_good ? ana_new : 32'h80808080;
          amode_d[i]        = commit_good && is_analog;
          ok_d[i]           = commit_good;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pad_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      id_q    <= '0;
      rxb_q   <= '0;
      acks_q  <= 1'b0;
      clk_q   <= 1'b1;
      cmd_q   <= 1'b1;
      sel_q   <= '1;
      btn_q   <= '0;
      ana_q   <= ANA_IDLE;
      amode_q <= '0;
      ok_q    <= '0;
      upd_q   <= 1'b0;
      updp_q  <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      id_q    <= id_d;
      rxb_q   <= rxb_d;
      acks_q  <= acks_d;
      clk_q   <= clk_d;
      cmd_q   <= cmd_d;
      sel_q   <= sel_d;
      btn_q   <= btn_d;
      ana_q   <= ana_d;
      amode_q <= amode_d;
      ok_q    <= ok_d;
      upd_q   <= upd_d;
      updp_q  <= updp_d;
    end
  end

  assign psx_clk     = clk_q;
  assign psx_cmd     = cmd_q;
  assign psx_sel     = sel_q;
  assign buttons     = btn_q;
  assign analog      = ana_q;
  assign analog_mode = amode_q;
  assign pad_ok      = ok_q;
  assign upd         = upd_q;
  assign upd_pad     = updp_q;

endmodule

// File: tb/tb_jtframe_psx_poll.sv
// Bench for jtframe_psx_poll: behavioural pad model on the bus plus a reply-level reference model.
module tb_jtframe_psx_poll;
  localparam int CLKDIV = 2;
  localparam int PADS   = 2;
  localparam int ACK_TO = 30;
  localparam int GAP    = 4;
  localparam int POLLC  = 40;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              psx_dat, psx_ack;
  logic              psx_clk, psx_cmd;
  logic [PADS-1:0]   psx_sel;
  logic [16*PADS-1:0] buttons;
  logic [32*PADS-1:0] analog;
  logic [PADS-1:0]   analog_mode, pad_ok;
  logic              upd;
  logic [1:0]        upd_pad;
  logic              vib_small;
  logic [7:0]        vib_large;

  jtframe_psx_poll #(
    .CLKDIV(CLKDIV), .PADS(PADS), .ACK_TO(ACK_TO), .GAP(GAP), .POLL_CYC(POLLC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .psx_dat(psx_dat), .psx_ack(psx_ack),
    .psx_clk(psx_clk), .psx_sel(psx_sel), .psx_cmd(psx_cmd),
    .buttons(buttons), .analog(analog), .analog_mode(analog_mode),
    .pad_ok(pad_ok), .upd(upd), .upd_pad(upd_pad),
    .vib_small(vib_small), .vib_large(vib_large)
  );

  always #5 clk = ~clk;

  // pad configuration and bus observations
  logic [7:0] reply [PADS][9];
  int         plen  [PADS];
  bit         ack_en[PADS];
  logic [7:0] cmdq[$];
  int m_cur, m_byte, m_bit;
  int multi_sel = 0;
  int min_gap   = 1000000;

  // reference expectations
  logic [15:0] e_btn [PADS];
  logic [31:0] e_ana [PADS];
  bit          e_mode[PADS];
  bit          e_ok  [PADS];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pad model: drives DAT on psx_clk fall, captures CMD on rise, pulses ACK after non-final bytes.
  initial begin : pad_model
    logic [7:0] cb;
    logic [7:0] rb;
    bit prev_clk;
    int ackdly, ackhold, idle_run;
    bit seen_active;
    psx_dat = 1'b1; psx_ack = 1'b1;
    prev_clk = 1'b1; ackdly = 0; ackhold = 0; idle_run = 0; seen_active = 0;
    m_cur = -1; m_byte = 0; m_bit = 0; cb = '0;
    forever begin
      @(negedge clk);
      m_cur = -1;
      for (int i = 0; i < PADS; i++) if (psx_sel[i] === 1'b0) m_cur = i;
      if ($countones(~psx_sel) > 1) multi_sel++;
      if (rst_n !== 1'b1) begin
        idle_run = 0; seen_active = 0;
      end else if (m_cur < 0) begin
        idle_run++;
      end else begin
        if (seen_active && idle_run > 0 && idle_run < min_gap) min_gap = idle_run;
        idle_run = 0; seen_active = 1;
      end
      if (m_cur < 0 || rst_n !== 1'b1) begin
        m_bit = 0; m_byte = 0; psx_dat = 1'b1; psx_ack = 1'b1;
        ackdly = 0; ackhold = 0; prev_clk = 1'b1;
      end else begin
        if (ackhold > 0) begin ackhold--; if (ackhold == 0) psx_ack = 1'b1; end
        if (ackdly > 0) begin
          ackdly--;
          if (ackdly == 0) begin psx_ack = 1'b0; ackhold = 2; end
        end
        if (prev_clk && !psx_clk && m_byte < 9) begin
          rb = reply[m_cur][m_byte];
          psx_dat = rb[m_bit];
        end
        if (!prev_clk && psx_clk) begin
          cb[m_bit] = psx_cmd;
          m_bit++;
          if (m_bit == 8) begin
            cmdq.push_back(cb);
            if (ack_en[m_cur] && m_byte < plen[m_cur] - 1) ackdly = $urandom_range(1, CLKDIV + 8);
            m_byte++;
            m_bit = 0;
          end
        end
        prev_clk = psx_clk;
      end
    end
  end

  // kind: 0 digital, 1 analog, 2 bad byte2, 3 bad ID, 4 no ACK
  task automatic set_pad(input int p, input int kind);
    logic [7:0] v;
    reply[p][0] = 8'hFF;
    reply[p][2] = 8'h5A;
    for (int b = 3; b < 9; b++) reply[p][b] = 8'($urandom);
    ack_en[p] = 1'b1;
    case (kind)
      0: reply[p][1] = 8'h41;
      1: reply[p][1] = 8'h73;
      2: begin
        reply[p][1] = ($urandom_range(0, 1) == 1) ? 8'h73 : 8'h41;
        v = 8'($urandom);
        reply[p][2] = (v == 8'h5A) ? 8'hFF : v;
      end
      3: begin
        v = 8'($urandom);
        reply[p][1] = (v == 8'h41 || v == 8'h73) ? 8'h23 : v;
      end
      default: begin reply[p][1] = 8'h41; ack_en[p] = 1'b0; end
    endcase
    plen[p] = (reply[p][1] == 8'h73) ? 9 : (kind == 3 ? 9 : 5);
  endtask

  // Reference: what a complete poll of pad p must produce, and how many bytes get clocked.
  task automatic model_commit(input int p, output int nb);
    logic [7:0] id;
    id = reply[p][1];
    if (!ack_en[p] || reply[p][2] != 8'h5A || !(id == 8'h41 || id == 8'h73)) begin
      nb = ack_en[p] ? 3 : 1;
      e_btn[p] = 16'h0000; e_ana[p] = 32'h80808080; e_mode[p] = 0; e_ok[p] = 0;
    end else begin
      nb = (id == 8'h73) ? 9 : 5;
      e_btn[p]  = ~{reply[p][4], reply[p][3]};
      e_ana[p]  = (id == 8'h73) ? {reply[p][8], reply[p][7], reply[p][6], reply[p][5]} : 32'h80808080;
      e_mode[p] = (id == 8'h73);
      e_ok[p]   = 1;
    end
  endtask

  function automatic logic [7:0] exp_cmd(input int b);
    if (b == 0) return 8'h01;
    if (b == 1) return 8'h42;
`ifdef JTFRAME_PSX_VIB_EN
    if (b == 3) return vib_small ? 8'hFF : 8'h00;
    if (b == 4) return vib_large;
`endif
    return 8'h00;
  endfunction

  task automatic reset_expect();
    for (int p = 0; p < PADS; p++) begin
      e_btn[p] = '0; e_ana[p] = 32'h80808080; e_mode[p] = 0; e_ok[p] = 0;
    end
  endtask

  task automatic step(input int p);
    bit got;
    int nb;
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (upd === 1'b1) got = 1;
    end
    chk("upd_seen", 64'(got), 64'd1);
    if (got) begin
      model_commit(p, nb);
      chk("upd_pad", 64'(upd_pad), 64'(p));
      chk("sel_high_at_commit", 64'(psx_sel), 64'(2'b11));
      for (int q = 0; q < PADS; q++) begin
        chk($sformatf("buttons%0d", q), 64'(buttons[16*q +: 16]), 64'(e_btn[q]));
        chk($sformatf("analog%0d", q), 64'(analog[32*q +: 32]), 64'(e_ana[q]));
        chk($sformatf("amode%0d", q), 64'(analog_mode[q]), 64'(e_mode[q]));
        chk($sformatf("pad_ok%0d", q), 64'(pad_ok[q]), 64'(e_ok[q]));
      end
      chk("bytes_clocked", 64'(cmdq.size()), 64'(nb));
      for (int b = 0; b < cmdq.size(); b++)
        chk($sformatf("cmd_byte%0d", b), 64'(cmdq[b]), 64'(exp_cmd(b)));
      cmdq.delete();
      @(negedge clk);
      chk("upd_one_cycle", 64'(upd), 64'd0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sel"}, 64'(psx_sel), 64'(2'b11));
    chk({tag, "_clk"}, 64'(psx_clk), 64'd1);
    chk({tag, "_cmd"}, 64'(psx_cmd), 64'd1);
    chk({tag, "_buttons"}, 64'(buttons), 64'd0);
    chk({tag, "_analog"}, 64'(analog), 64'h8080808080808080);
    chk({tag, "_amode"}, 64'(analog_mode), 64'd0);
    chk({tag, "_pad_ok"}, 64'(pad_ok), 64'd0);
    chk({tag, "_upd"}, 64'(upd), 64'd0);
    chk({tag, "_upd_pad"}, 64'(upd_pad), 64'd0);
  endtask

  initial begin : main
    bit got;
    rst_n = 1'b0;
    vib_small = 1'b1;
    vib_large = 8'h7F;
    reset_expect();
    // pad0: digital 0x41/0x5A/0xFE/0xFF; pad1: analog with sticks 0x10..0x40
    set_pad(0, 0);
    reply[0][3] = 8'hFE; reply[0][4] = 8'hFF;
    set_pad(1, 1);
    reply[1][5] = 8'h10; reply[1][6] = 8'h20; reply[1][7] = 8'h30; reply[1][8] = 8'h40;
    repeat (4) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    step(0);
    chk("t1_buttons", 64'(buttons[15:0]), 64'h0001);
    set_pad(0, 2);
    step(1);
    chk("t2_analog", 64'(analog[63:32]), 64'h40302010);
    set_pad(1, 4);
    step(0);
    set_pad(0, 0);
    step(1);
    set_pad(1, 3);
    step(0);
    set_pad(1, 3);
    step(1);

    for (int r = 0; r < 6; r++) begin
      set_pad(1, (r == 5) ? 1 : int'($urandom_range(0, 4)));
      step(0);
      set_pad(0, (r == 5) ? 0 : int'($urandom_range(0, 4)));
      step(1);
    end
    step(0);
    step(1);

    // reset in the middle of pad 0's byte 3
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (m_cur == 0 && m_byte == 3 && m_bit == 4) got = 1;
    end
    chk("reach_byte3", 64'(got), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    cmdq.delete();
    reset_expect();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(0);
    step(1);

    chk("single_sel", 64'(multi_sel), 64'd0);
    chk("min_gap_ok", 64'(min_gap >= GAP), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
